// File: rtl/register_bank_sync.sv
// register_bank_sync
//   MIPS-style register file with two synchronous read ports and one write port.
//   Read data is registered, so it appears one cycle after the address.
//   A write and a read of the same address on the same edge return the new data.
//   After reset a clear sequencer zeroes one entry per cycle. ready rises once the
//   whole file has been cleared.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous, active-high reset
//   dir_read1   in   ADDR_W  read address, port 1
//   dir_read2   in   ADDR_W  read address, port 2
//   dir_write   in   ADDR_W  write address
//   write_data  in   DATA_W  write data
//   wena        in   1       write enable (ignored while clearing)
//   bus1        out  DATA_W  registered read data, port 1
//   bus2        out  DATA_W  registered read data, port 2
//   ready       out  1       1 = clear finished, normal operation

module register_bank_sync #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] dir_read1,
   input  logic [ADDR_W-1:0] dir_read2,
   input  logic [ADDR_W-1:0] dir_write,
   input  logic [DATA_W-1:0] write_data,
   input  logic              wena,
   output logic [DATA_W-1:0] bus1,
   output logic [DATA_W-1:0] bus2,
   output logic              ready
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      StClear,
      StRun
   } state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [ADDR_W-1:0]   r_clr_ptr;
   logic [ADDR_W-1:0]   w_clr_ptr_next;
   logic                r_ready;
   logic                w_ready_next;
   logic [DATA_W-1:0]   r_bus1;
   logic [DATA_W-1:0]   r_bus2;
   logic [DATA_W-1:0]   w_bus1_next;
   logic [DATA_W-1:0]   w_bus2_next;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_zero_en;
   logic                w_wr_en;
   logic                w_clr_en;
   logic [DATA_W-1:0]   w_rd1;
   logic [DATA_W-1:0]   w_rd2;

   assign w_zero_en = (ZERO_REG != 0);

   // Writes to the hardwired zero entry are dropped, so the bypass must drop them too.
   assign w_wr_en  = !rst && (r_state == StRun) && wena &&
                     !(w_zero_en && (dir_write == '0));
   assign w_clr_en = !rst && (r_state == StClear);

   always_comb begin
      w_rd1 = r_mem[dir_read1];
      if (w_zero_en && (dir_read1 == '0)) begin
         w_rd1 = '0;
      end else if (w_wr_en && (dir_write == dir_read1)) begin
         w_rd1 = write_data;
      end
   end

   always_comb begin
      w_rd2 = r_mem[dir_read2];
      if (w_zero_en && (dir_read2 == '0)) begin
         w_rd2 = '0;
      end else if (w_wr_en && (dir_write == dir_read2)) begin
         w_rd2 = write_data;
      end
   end

   // Next-state logic for the clear sequencer and the read registers.
   always_comb begin
      w_state_next   = r_state;
      w_clr_ptr_next = r_clr_ptr;
      w_ready_next   = r_ready;
      w_bus1_next    = '0;
      w_bus2_next    = '0;
      unique case (r_state)
         StClear: begin
            w_clr_ptr_next = r_clr_ptr + 1'b1;
            if (&r_clr_ptr) begin
               w_state_next = StRun;
               w_ready_next = 1'b1;
            end
         end
         StRun: begin
            w_bus1_next = w_rd1;
            w_bus2_next = w_rd2;
         end
         default: begin
            w_state_next = StClear;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StClear;
         r_clr_ptr <= '0;
         r_ready   <= 1'b0;
         r_bus1    <= '0;
         r_bus2    <= '0;
      end else begin
         r_state   <= w_state_next;
         r_clr_ptr <= w_clr_ptr_next;
         r_ready   <= w_ready_next;
         r_bus1    <= w_bus1_next;
         r_bus2    <= w_bus2_next;
      end
   end

   // Storage has no reset of its own; the clear sequencer initialises it.
   always_ff @(posedge clk) begin
      if (w_clr_en) begin
         r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_en) begin
         r_mem[dir_write] <= write_data;
      end
   end

   assign bus1  = r_bus1;
   assign bus2  = r_bus2;
   assign ready = r_ready;

endmodule

// File: tb/tb_register_bank_sync.sv
// tb_register_bank_sync
//   Directed bench for register_bank_sync. Two instances share all inputs:
//   u_z1 has ZERO_REG=1, u_z0 has ZERO_REG=0. Outputs are sampled 1 time unit
//   after each rising edge, where new inputs are also applied.

module tb_register_bank_sync;

   logic        clk;
   logic        rst;
   logic [4:0]  dir_read1;
   logic [4:0]  dir_read2;
   logic [4:0]  dir_write;
   logic [31:0] write_data;
   logic        wena;
   logic [31:0] z1_bus1;
   logic [31:0] z1_bus2;
   logic        z1_ready;
   logic [31:0] z0_bus1;
   logic [31:0] z0_bus2;
   logic        z0_ready;

   int n_vec;
   int n_err;

   register_bank_sync #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .ZERO_REG (1)
   ) u_z1 (
      .clk        (clk),
      .rst        (rst),
      .dir_read1  (dir_read1),
      .dir_read2  (dir_read2),
      .dir_write  (dir_write),
      .write_data (write_data),
      .wena       (wena),
      .bus1       (z1_bus1),
      .bus2       (z1_bus2),
      .ready      (z1_ready)
   );

   register_bank_sync #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .ZERO_REG (0)
   ) u_z0 (
      .clk        (clk),
      .rst        (rst),
      .dir_read1  (dir_read1),
      .dir_read2  (dir_read2),
      .dir_write  (dir_write),
      .write_data (write_data),
      .wena       (wena),
      .bus1       (z0_bus1),
      .bus2       (z0_bus2),
      .ready      (z0_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] e1_z1, input logic [31:0] e2_z1,
                            input logic [31:0] e1_z0, input logic [31:0] e2_z0);
      check({tag, " z1.bus1"}, z1_bus1, e1_z1);
      check({tag, " z1.bus2"}, z1_bus2, e2_z1);
      check({tag, " z0.bus1"}, z0_bus1, e1_z0);
      check({tag, " z0.bus2"}, z0_bus2, e2_z0);
   endtask

   task automatic check_ready(input string tag, input logic exp);
      check({tag, " z1.ready"}, {31'd0, z1_ready}, {31'd0, exp});
      check({tag, " z0.ready"}, {31'd0, z0_ready}, {31'd0, exp});
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      dir_read1  = '0;
      dir_read2  = '0;
      dir_write  = '0;
      write_data = '0;
      wena       = 1'b0;

      // T1 reset, with T6 stimulus: write r9 continuously while clearing
      step();
      check_ready("reset", 1'b0);
      check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0);
      rst        = 1'b0;
      wena       = 1'b1;
      dir_write  = 5'd9;
      write_data = 32'h55;
      dir_read1  = 5'd9;
      dir_read2  = 5'd9;
      for (int k = 1; k <= 32; k++) begin
         step();
         check_ready($sformatf("clear edge %0d", k), (k == 32));
         check_all($sformatf("clear edge %0d", k), 32'h0, 32'h0, 32'h0, 32'h0);
      end
      wena = 1'b0;

      // T6 r9 must still read 0
      step();
      check_all("T6 r9", 32'h0, 32'h0, 32'h0, 32'h0);

      // T2 write then read
      wena       = 1'b1;
      dir_write  = 5'd5;
      write_data = 32'hDEADBEEF;
      dir_read1  = 5'd0;
      dir_read2  = 5'd0;
      step();
      check_all("T2 wr", 32'h0, 32'h0, 32'h0, 32'h0);
      wena      = 1'b0;
      dir_read1 = 5'd5;
      step();
      check_all("T2 rd", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);

      // T3 bypass on both ports
      wena       = 1'b1;
      dir_write  = 5'd7;
      write_data = 32'h12345678;
      dir_read1  = 5'd7;
      dir_read2  = 5'd7;
      step();
      check_all("T3 byp", 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
      wena = 1'b0;
      step();
      check_all("T3 mem", 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);

      // T4 zero register with bypass, then from storage
      wena       = 1'b1;
      dir_write  = 5'd0;
      write_data = 32'hFFFFFFFF;
      dir_read1  = 5'd0;
      dir_read2  = 5'd5;
      step();
      check_all("T4 byp", 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF);
      wena = 1'b0;
      step();
      check_all("T4 mem", 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF);

      // back-to-back writes to one address
      wena       = 1'b1;
      dir_write  = 5'd12;
      write_data = 32'h11111111;
      dir_read1  = 5'd3;
      dir_read2  = 5'd3;
      step();
      write_data = 32'h22222222;
      step();
      wena      = 1'b0;
      dir_read1 = 5'd12;
      step();
      check_all("b2b", 32'h22222222, 32'h0, 32'h22222222, 32'h0);

      // T5 write r3, reset, restart clear mid-way, r3 must read 0 afterwards
      wena       = 1'b1;
      dir_write  = 5'd3;
      write_data = 32'hA5A5A5A5;
      step();
      wena      = 1'b0;
      dir_read1 = 5'd3;
      dir_read2 = 5'd0;
      step();
      check_all("T5 r3", 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'hFFFFFFFF);
      rst = 1'b1;
      step();
      check_ready("T5 rst1", 1'b0);
      check_all("T5 rst1", 32'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
      end
      check_ready("T5 clr10", 1'b0);
      rst = 1'b1;
      step();
      check_all("T5 rst2", 32'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         step();
         check_ready($sformatf("T5 edge %0d", k), (k == 32));
      end
      dir_read1 = 5'd3;
      dir_read2 = 5'd0;
      step();
      check_all("T5 after", 32'h0, 32'h0, 32'h0, 32'h0);
      dir_read1 = 5'd5;
      dir_read2 = 5'd7;
      step();
      check_all("T5 cleared", 32'h0, 32'h0, 32'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
